systolic_seq: RTL and testbench

Sequencer for an N×N output-stationary systolic array of 32-bit multiply-accumulate PEs. It clears the array, fetches one column of A and one row of B per cycle from the tile buffers, and skews them onto the array's left and top edges. It gates the array enable for exactly the number of cycles needed to flush every product into every accumulator, then signals completion. It sits between the tile buffers / host control logic and the PE grid.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/skew_line.sv | 36 +++
 rtl/systolic_seq.sv | 164 ++++++++++++++++
 tb/tb_systolic_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding and
// default lane geometry.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FIN
  } state_e;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 32;
  localparam int LANE_W = DW_DEF;

endpackage

// File: rtl/skew_line.sv
// Enable-gated delay line of DEPTH stages with synchronous clear; used to
// stagger one edge lane of the systolic array feed.
module skew_line
  import systolic_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = LANE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DEPTH-1:0][DW-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    if (clr) begin
      pipe_d = '0;
    end else if (en) begin
      pipe_d[0] = d;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_seq.sv
// Output-stationary systolic array sequencer: clear, skewed feed, flush, done.
// Optional cycle counter enabled by defining SYSTOLIC_SEQ_PERF_EN.
//
// state | meaning
// IDLE  | waiting for START, K_LEN latched on acceptance
// CLEAR | one-cycle accumulator clear, skew reset, prefetch of k=0
// RUN   | step counter t advances 0..K+2N-2 while HOLD is low
// FIN   | one-cycle DONE pulse, array enable held low
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = LANE_W,
  parameter int KW = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic [KW-1:0]   K_LEN,
  input  logic            HOLD,
  output logic            BUF_RD_EN,
  output logic [KW-1:0]   BUF_K,
  input  logic [N*DW-1:0] BUF_A,
  input  logic [N*DW-1:0] BUF_B,
  output logic [N*DW-1:0] ARR_A,
  output logic [N*DW-1:0] ARR_B,
  output logic            ARR_EN,
  output logic            ARR_CLR,
  output logic            BUSY,
  output logic            DONE,
  output logic [31:0]     CYC_CNT
);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW:0]   t_q, t_d;
  logic          clr_q, clr_d, busy_q, busy_d, done_q, done_d;
  logic          pref_q, pref_d, run_q, run_d;

  logic          advance, rd_run, lane_valid;
  logic [KW:0]   t_plus1, t_last, k_ext;

  assign k_ext   = {1'b0, k_q};
  assign t_plus1 = t_q + (KW+1)'(1);
  assign t_last  = k_ext + (KW+1)'(2*N-2);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    pref_d  = 1'b0;
    busy_d  = busy_q;
    run_d   = run_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_CLEAR;
          k_d     = K_LEN;
          t_d     = '0;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
          pref_d  = (K_LEN != '0);
        end
      end
      ST_CLEAR: begin
        if (k_q != '0) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end else begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!HOLD) begin
          if (t_q == t_last) begin
            state_d = ST_FIN;
            run_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            t_d = t_plus1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      pref_q  <= 1'b0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      pref_q  <= pref_d;
      busy_q  <= busy_d;
      run_q   <= run_d;
    end
  end

  // HOLD must stall the array in the same cycle, so the enables stay combinational on it.
  assign advance    = run_q & ~HOLD;
  assign rd_run     = advance & (t_plus1 < k_ext);
  assign lane_valid = run_q & (t_q < k_ext);

  assign BUF_RD_EN = pref_q | rd_run;
  assign BUF_K     = rd_run ? t_plus1[KW-1:0] : '0;
  assign ARR_EN    = advance;
  assign ARR_CLR   = clr_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

  logic [N*DW-1:0] a_gated, b_gated;
  assign a_gated = lane_valid ? BUF_A : '0;
  assign b_gated = lane_valid ? BUF_B : '0;

  assign ARR_A[DW-1:0] = a_gated[DW-1:0];
  assign ARR_B[DW-1:0] = b_gated[DW-1:0];

  for (genvar i = 1; i < N; i++) begin : g_skew
    skew_line #(.DEPTH(i), .DW(DW)) u_skew_a (
      .clk(CLK), .rst_n(RST_N), .en(advance), .clr(clr_q),
      .d(a_gated[i*DW +: DW]), .q(ARR_A[i*DW +: DW])
    );
    skew_line #(.DEPTH(i), .DW(DW)) u_skew_b (
      .clk(CLK), .rst_n(RST_N), .en(advance), .clr(clr_q),
      .d(b_gated[i*DW +: DW]), .q(ARR_B[i*DW +: DW])
    );
  end

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_IDLE && START) cyc_d = '0;
    else if (busy_q)                 cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign CYC_CNT = cyc_q;
`else
  assign CYC_CNT = '0;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq: N=2 instance with a 2x2 array model and
// an N=4 instance for skew-lane checks.
module tb_systolic_seq;

`ifdef SYSTOLIC_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // N=2 instance
  logic        start2 = 1'b0, hold2 = 1'b0;
  logic [15:0] k2 = '0;
  logic        rd2, en2, clr2, busy2, done2;
  logic [15:0] bk2;
  logic [63:0] bufa2 = '0, bufb2 = '0;
  logic [63:0] arra2, arrb2;
  logic [31:0] cyc2;
  logic [63:0] mem_a2 [0:3];
  logic [63:0] mem_b2 [0:3];

  systolic_seq #(.N(2), .DW(32), .KW(16)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .K_LEN(k2), .HOLD(hold2),
    .BUF_RD_EN(rd2), .BUF_K(bk2), .BUF_A(bufa2), .BUF_B(bufb2),
    .ARR_A(arra2), .ARR_B(arrb2), .ARR_EN(en2), .ARR_CLR(clr2),
    .BUSY(busy2), .DONE(done2), .CYC_CNT(cyc2)
  );

  // N=4 instance
  logic         start4 = 1'b0, hold4 = 1'b0;
  logic [15:0]  k4 = '0;
  logic         rd4, en4, clr4, busy4, done4;
  logic [15:0]  bk4;
  logic [127:0] bufa4 = '0, bufb4 = '0;
  logic [127:0] arra4, arrb4;
  logic [31:0]  cyc4;
  logic [127:0] mem_t4 [0:3];

  systolic_seq #(.N(4), .DW(32), .KW(16)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .START(start4), .K_LEN(k4), .HOLD(hold4),
    .BUF_RD_EN(rd4), .BUF_K(bk4), .BUF_A(bufa4), .BUF_B(bufb4),
    .ARR_A(arra4), .ARR_B(arrb4), .ARR_EN(en4), .ARR_CLR(clr4),
    .BUSY(busy4), .DONE(done4), .CYC_CNT(cyc4)
  );

  // Tile buffers: data appears one cycle after the read strobe and holds otherwise.
  always @(posedge clk) begin
    if (rd2) begin
      bufa2 <= mem_a2[bk2[1:0]];
      bufb2 <= mem_b2[bk2[1:0]];
    end
    if (rd4) begin
      bufa4 <= mem_t4[bk4[1:0]];
      bufb4 <= mem_t4[bk4[1:0]];
    end
  end

  // 2x2 output-stationary PE grid: operands hop one PE per enabled cycle.
  logic [31:0] acc [0:1][0:1];
  logic [31:0] a_r [0:1][0:1];
  logic [31:0] b_r [0:1][0:1];

  always @(posedge clk) begin : pe_grid
    logic [31:0] ain, bin;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (clr2) begin
          acc[i][j] <= '0;
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
        end else if (en2) begin
          ain = (j == 0) ? arra2[i*32 +: 32] : a_r[i][j-1];
          bin = (i == 0) ? arrb2[j*32 +: 32] : b_r[i-1][j];
          acc[i][j] <= acc[i][j] + ain * bin;
          a_r[i][j] <= ain;
          b_r[i][j] <= bin;
        end
      end
    end
  end

  task automatic chki(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag);
    chki({tag, "_c00"}, int'(acc[0][0]), 19);
    chki({tag, "_c01"}, int'(acc[0][1]), 22);
    chki({tag, "_c10"}, int'(acc[1][0]), 43);
    chki({tag, "_c11"}, int'(acc[1][1]), 50);
  endtask

  // One tile on the N=2 instance; cycle n is the n-th cycle after the accepting edge.
  task automatic run2(input int k, input bit sh, input int hs, input int hl,
                      output int dc, output int enc, output int rdc,
                      output int clrc, output int clrcyc);
    int n;
    logic [63:0] sa, sb;
    dc = -1; enc = 0; rdc = 0; clrc = 0; clrcyc = -1;
    sa = '0; sb = '0;
    #1;
    k2 = 16'(k);
    start2 = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 60 && dc < 0) begin
      n++;
      #1;
      start2 = sh;
      hold2 = (n >= hs && n < hs + hl);
      @(negedge clk);
      if (en2) enc++;
      if (rd2) rdc++;
      if (clr2) begin clrc++; clrcyc = n; end
      if (done2) dc = n;
      if (hl > 0 && n == hs) begin
        sa = arra2;
        sb = arrb2;
        chkv("hold_a_val", 128'(arra2), 128'({32'd4, 32'd0}));
        chkv("hold_b_val", 128'(arrb2), 128'({32'd8, 32'd0}));
      end
      if (hl > 0 && n > hs && n < hs + hl) begin
        chkv("hold_a_frozen", 128'(arra2), 128'(sa));
        chkv("hold_b_frozen", 128'(arrb2), 128'(sb));
      end
      @(posedge clk);
    end
    hold2 = 1'b0;
  endtask

  logic [31:0] exp_a4_l2 [0:6];
  logic [31:0] exp_b4_l1 [0:4];

  initial begin
    int dc, enc, rdc, clrc, clrcyc, w, dn, n, t, dc4;

    mem_a2[0] = {32'd3, 32'd1};
    mem_a2[1] = {32'd4, 32'd2};
    mem_a2[2] = '0;
    mem_a2[3] = '0;
    mem_b2[0] = {32'd6, 32'd5};
    mem_b2[1] = {32'd8, 32'd7};
    mem_b2[2] = '0;
    mem_b2[3] = '0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        mem_t4[k][i*32 +: 32] = (k < 3) ? 32'((k << 8) | i) : 32'd0;
    exp_a4_l2 = '{32'h0, 32'h0, 32'h002, 32'h102, 32'h202, 32'h0, 32'h0};
    exp_b4_l1 = '{32'h0, 32'h001, 32'h101, 32'h201, 32'h0};

    // Reset state
    #12;
    chki("rst_busy", int'(busy2), 0);
    chki("rst_en", int'(en2), 0);
    chki("rst_rd", int'(rd2), 0);
    chkv("rst_arr_a", 128'(arra2), 128'(0));
    chki("rst_cyc", int'(cyc2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 2x2 tile, K=2
    run2(2, 1'b0, 0, 0, dc, enc, rdc, clrc, clrcyc);
    chki("basic_done_cyc", dc, 7);
    chki("basic_en_cnt", enc, 5);
    chki("basic_rd_cnt", rdc, 2);
    chki("basic_clr_cyc", clrcyc, 1);
    chk_result("basic");
    chki("basic_cyc_cnt", int'(cyc2), PERF ? 6 : 0);

    // Skew on N=4, K=3
    #1;
    k4 = 16'd3;
    start4 = 1'b1;
    @(posedge clk);
    n = 0;
    dc4 = -1;
    while (n < 40 && dc4 < 0) begin
      n++;
      #1;
      start4 = 1'b0;
      @(negedge clk);
      t = n - 2;
      if (t >= 0 && t <= 6) chki("skew_a_l2", int'(arra4[64 +: 32]), int'(exp_a4_l2[t]));
      if (t >= 0 && t <= 4) chki("skew_b_l1", int'(arrb4[32 +: 32]), int'(exp_b4_l1[t]));
      if (t == 6) begin
        chkv("skew_a_zero", arra4, 128'(0));
        chkv("skew_b_zero", arrb4, 128'(0));
      end
      if (done4) dc4 = n;
      @(posedge clk);
    end
    chki("skew_done_cyc", dc4, 12);

    // K_LEN = 0
    run2(0, 1'b0, 0, 0, dc, enc, rdc, clrc, clrcyc);
    chki("k0_done_cyc", dc, 2);
    chki("k0_clr_cyc", clrcyc, 1);
    chki("k0_rd_cnt", rdc, 0);
    chki("k0_en_cnt", enc, 0);
    chki("k0_cyc_cnt", int'(cyc2), PERF ? 1 : 0);

    // HOLD for three cycles at t=2
    run2(2, 1'b0, 4, 3, dc, enc, rdc, clrc, clrcyc);
    chki("hold_done_cyc", dc, 10);
    chki("hold_en_cnt", enc, 5);
    chk_result("hold");
    chki("hold_cyc_cnt", int'(cyc2), PERF ? 9 : 0);

    // START held high through a tile, then back-to-back restart
    run2(2, 1'b1, 0, 0, dc, enc, rdc, clrc, clrcyc);
    chki("sh_done_cyc", dc, 7);
    chki("sh_clr_cnt", clrc, 1);
    #1;
    chki("sh_idle_busy", int'(busy2), 0);
    @(posedge clk);
    #1;
    chki("sh_restart_clr", int'(clr2), 1);
    start2 = 1'b0;
    w = 0;
    @(negedge clk);
    while (!done2 && w < 30) begin
      @(negedge clk);
      w++;
    end
    chki("sh_second_done", int'(done2), 1);
    chk_result("sh2");

    // Asynchronous reset in the middle of RUN
    @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chki("pre_rst_busy", int'(busy2), 1);
    rst_n = 1'b0;
    #1;
    chki("arst_en", int'(en2), 0);
    chki("arst_busy", int'(busy2), 0);
    chki("arst_rd", int'(rd2), 0);
    chki("arst_bufk", int'(bk2), 0);
    chkv("arst_arr_a", 128'(arra2), 128'(0));
    chkv("arst_arr_b", 128'(arrb2), 128'(0));
    chki("arst_cyc", int'(cyc2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done2) dn++;
    end
    chki("arst_no_done", dn, 0);
    run2(2, 1'b0, 0, 0, dc, enc, rdc, clrc, clrcyc);
    chki("post_rst_done_cyc", dc, 7);
    chk_result("post_rst");
    chki("post_rst_cyc_cnt", int'(cyc2), PERF ? 6 : 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
